osel_bit_arbiter: RTL and testbench
===================================

# osel_bit_arbiter

Round-robin arbiter that shares one 8-bit output-select register (`osel`) between several requesters, each writing one bit per transfer. Each requester presents a bit index and a bit value over a valid/ready handshake. The arbiter grants one requester per cycle and commits the bit write on the next clock edge. A requester can lock the grant for back-to-back writes; lock has a timeout. The block sits between the instruction-decode requesters and the registered `osel` output bus in the core's control path.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: width of `osel`.
- `IDXW`, default 3: bit-index width; equals `$clog2(WIDTH)`.
- `LOCK_TMO`, default 15: idle cycles before a held lock is released (1..255).

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `clr`  in  1: synchronous clear of `osel`.
- `req_valid`  in  NREQ: request valid, one bit per requester.
- `req_ready`  out  NREQ: one-hot or zero; grant for the current cycle.
- `req_idx`  in  NREQ*IDXW: bit index; requester i uses slice [i*IDXW +: IDXW].
- `req_val`  in  NREQ: value written to `osel[idx]`.
- `req_lock`  in  NREQ: when set on an accepted beat, hold the grant after this beat.
- `osel`  out  WIDTH: registered output-select register.
- `osel_wr`  out  1: one-cycle pulse, high in the cycle after a committed write.
- `grant_id`  out  3: index of the last accepted requester.
- `locked`  out  1: high while in the LOCKED state.

## Operation
- **States:** IDLE and LOCKED. Round-robin pointer `rr_ptr` (0..NREQ-1).
- **IDLE arbitration:**
  - Search for the first valid requester, starting at `rr_ptr` and wrapping.
  - Drive `req_ready` high for that requester only.
  - Transfer occurs when `req_valid[i] & req_ready[i]`.
  - On transfer: `rr_ptr <= (i+1) mod NREQ`; `grant_id <= i`.
  - If `req_lock[i]` is set: go to LOCKED with owner i, and zero the timeout counter.
- **LOCKED:**
  - Only the owner can receive `req_ready`; all other requesters see 0.
  - Owner transfer with lock=1: stay in LOCKED, reset the counter.
  - Owner transfer with lock=0: return to IDLE.
  - Owner valid low: the counter increments. When it reaches `LOCK_TMO`, return to IDLE.
  - `rr_ptr` does not change while locked. It is updated to owner+1 on exit.
- **Commit:** an accepted beat writes `osel[idx] <= val` at the same edge. All other bits hold.
- **Out-of-range index:** if `idx >= WIDTH`, the beat is accepted but not written, and `osel_wr` stays low.
- **clr:**
  - Forces all `req_ready` to 0 that cycle, so no transfer happens.
  - `osel <= 0` at the edge.
  - FSM state, lock ownership and counter are unchanged.
- **reset:**
  - `osel=0`, `osel_wr=0`, `grant_id=0`, `locked=0`, `rr_ptr=0`, state IDLE, counter 0.
  - `req_ready` is all zero while `reset` is high.
  - Reset mid-lock drops the lock immediately.

## Timing
- `req_ready` is combinational from `req_valid`, state, `rr_ptr`, `clr` and `reset`. There is no combinational path from `req_idx`/`req_val` to `req_ready`.
- Latency: a beat accepted in cycle N gives new `osel` and `osel_wr=1` in cycle N+1.
- Throughput: one write per cycle sustained, including the locked owner writing every cycle.
- Two writes to the same bit in consecutive cycles: the later one wins, and each produces its own pulse.
- Lock timeout: with the owner idle from cycle N, `locked` falls in cycle N+`LOCK_TMO`. Arbitration among all requesters resumes in that same cycle.
- A requester may hold `req_valid` with stable payload across any number of cycles without ready. Payload is sampled only on transfer.

## Structure
- Shared package `osel_pkg`: FSM state enum (`OS_IDLE`, `OS_LOCKED`), default `WIDTH`/`NREQ`/`LOCK_TMO` constants.
- One sub-module: `rr_pick`. It is a purely combinational rotate-priority picker (valid vector + pointer → one-hot + index + any).
- Top: FSM, counter, pointer and `osel` register.

## Test plan
- **Reset:** hold `reset` 2 cycles with all valids high → `req_ready`=0; after release, `osel`=8'h00, `locked`=0, `grant_id`=0.
- **Single write:** req1 idx=3 val=1 → `req_ready`=4'b0010 same cycle; next cycle `osel`=8'h08, `osel_wr`=1.
- **Fairness:** all 4 valid continuously, distinct idx 0..3, val=1 → grants in order 0,1,2,3,0; `osel`=8'h0F after 4 beats.
- **Lock:**
  - req2 lock=1 for 3 beats (idx 5,6,7) while req0/req1 are valid → only req2 is served; `osel`=8'hE0.
  - Final beat lock=0 → next grant is req3 if valid, else req0.
- **Timeout:** LOCK_TMO=4; req0 locks then drops valid, req1 valid → `locked` falls 4 cycles later, and req1 is granted that cycle.
- **clr and out-of-range:**
  - `osel`=8'hFF, `clr` asserted with req0 valid → no ready that cycle; `osel`=0 next cycle.
  - WIDTH=6, idx=7 → accepted, `osel` unchanged, `osel_wr`=0.

Source files
------------

// File: rtl/osel_pkg.sv
// osel_pkg: shared FSM state type, default sizes and pointer helper for the osel bit arbiter
package osel_pkg;
  typedef enum logic {OS_IDLE, OS_LOCKED} os_state_e;
  localparam int DEF_NREQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LOCK_TMO = 15;
  function automatic logic [2:0] rr_next(input logic [2:0] i, input int n);
    return (int'(i) + 1 >= n) ? 3'd0 : i + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker, nearest valid requester at or after ptr wins
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid,
  input  logic [2:0]   ptr,
  output logic [N-1:0] onehot,
  output logic [2:0]   idx,
  output logic         any
);
  int best;
  int d;
  // pick the valid requester with the smallest rotated distance from ptr
  always_comb begin
    best = N;
    d = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i - int'(ptr) + N) % N;
      if (valid[i] && d < best) begin
        best = d;
        idx = 3'(i);
      end
    end
    any = |valid;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/osel_bit_arbiter.sv
// osel_bit_arbiter: round-robin arbiter with lock/timeout committing single-bit writes into osel
module osel_bit_arbiter
  import osel_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW = $clog2(WIDTH),
  parameter int LOCK_TMO = DEF_LOCK_TMO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ-1:0]      req_val,
  input  logic [NREQ-1:0]      req_lock,
  output logic [WIDTH-1:0]     osel,
  output logic                 osel_wr,
  output logic [2:0]           grant_id,
  output logic                 locked
);
  os_state_e state, state_n;
  logic [2:0] rr_ptr, rr_ptr_n, owner, owner_n, grant_n, pick_idx, xid;
  logic [7:0] cnt, cnt_n;
  logic [NREQ-1:0] pick_oh;
  logic pick_any, xfer, sel_val, sel_lock, wr_n;
  logic [IDXW-1:0] sel_idx;
  logic [WIDTH-1:0] osel_n;

  rr_pick #(.N(NREQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );

  // grant selection, payload mux of the granted requester and next osel value
  always_comb begin
    req_ready = (reset || clr) ? '0
              : (state == OS_LOCKED) ? req_valid & (NREQ'(1) << owner)
              : (pick_any ? pick_oh : '0);
    xid = (state == OS_LOCKED) ? owner : pick_idx;
    xfer = |req_ready;
    sel_idx = '0;
    sel_val = 1'b0;
    sel_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_idx = req_idx[i*IDXW +: IDXW];
        sel_val = req_val[i];
        sel_lock = req_lock[i];
      end
    end
    wr_n = xfer && (32'(sel_idx) < WIDTH);
    osel_n = clr ? '0 : osel;
    for (int b = 0; b < WIDTH; b++)
      if (wr_n && 32'(sel_idx) == b) osel_n[b] = sel_val;
  end

  // lock FSM: clr freezes state, owner and counter; idle owner times out after LOCK_TMO cycles
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n = cnt;
    rr_ptr_n = rr_ptr;
    grant_n = xfer ? xid : grant_id;
    if (!clr) begin
      if (state == OS_IDLE) begin
        if (xfer) begin
          rr_ptr_n = rr_next(xid, NREQ);
          if (sel_lock) begin
            state_n = OS_LOCKED;
            owner_n = xid;
            cnt_n = '0;
          end
        end
      end else if (xfer) begin
        cnt_n = '0;
        if (!sel_lock) begin
          state_n = OS_IDLE;
          rr_ptr_n = rr_next(owner, NREQ);
        end
      end else begin
        cnt_n = cnt + 8'd1;
        if (32'(cnt) + 1 >= LOCK_TMO) begin
          state_n = OS_IDLE;
          rr_ptr_n = rr_next(owner, NREQ);
        end
      end
    end
  end

  // state, pointer, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OS_IDLE;
      owner <= '0;
      cnt <= '0;
      rr_ptr <= '0;
      grant_id <= '0;
      osel <= '0;
      osel_wr <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt <= cnt_n;
      rr_ptr <= rr_ptr_n;
      grant_id <= grant_n;
      osel <= osel_n;
      osel_wr <= wr_n;
    end
  end

  assign locked = state == OS_LOCKED;
endmodule

// File: tb/tb_osel_bit_arbiter.sv
// tb_osel_bit_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_osel_bit_arbiter;
  localparam int N = 4;
  localparam int W = 6;
  localparam int IW = 3;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst, clr;
  logic [N-1:0] valid, ready, val, lock;
  logic [N*IW-1:0] idx;
  logic [W-1:0] osel;
  logic osel_wr, locked;
  logic [2:0] grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  bit locked_m, wr_m;
  int owner_m, ptr_m, idle_m, gid_m;
  logic [W-1:0] osel_m;

  osel_bit_arbiter #(.NREQ(N), .WIDTH(W), .IDXW(IW), .LOCK_TMO(TMO)) dut (
    .clk(clk),
    .reset(rst),
    .clr(clr),
    .req_valid(valid),
    .req_ready(ready),
    .req_idx(idx),
    .req_val(val),
    .req_lock(lock),
    .osel(osel),
    .osel_wr(osel_wr),
    .grant_id(grant_id),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst || clr) return r;
    if (locked_m) begin
      if (valid[owner_m]) r[owner_m] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++)
      if (valid[(ptr_m + k) % N]) begin
        r[(ptr_m + k) % N] = 1'b1;
        return r;
      end
    return r;
  endfunction

  task automatic drive(input int i, input logic v, input int ix, input logic vl, input logic lk);
    valid[i] = v;
    idx[i*IW +: IW] = IW'(ix);
    val[i] = vl;
    lock[i] = lk;
  endtask

  task automatic step(input string tag);
    logic [N-1:0] er;
    int g, ix;
    logic vb, lb, rb, cb;
    #1;
    er = exp_ready();
    check({tag, "/ready"}, 32'(ready), 32'(er));
    g = -1;
    ix = 0;
    vb = 1'b0;
    lb = 1'b0;
    for (int i = 0; i < N; i++) if (er[i]) g = i;
    if (g >= 0) begin
      ix = int'(idx[g*IW +: IW]);
      vb = val[g];
      lb = lock[g];
    end
    rb = rst;
    cb = clr;
    @(posedge clk);
    if (rb) begin
      osel_m = '0; wr_m = 0; gid_m = 0; locked_m = 0; ptr_m = 0; idle_m = 0; owner_m = 0;
    end else begin
      wr_m = 0;
      if (cb) osel_m = '0;
      else if (g >= 0) begin
        gid_m = g;
        if (ix < W) begin
          osel_m[ix] = vb;
          wr_m = 1;
        end
        if (!locked_m) begin
          ptr_m = (g + 1) % N;
          if (lb) begin
            locked_m = 1; owner_m = g; idle_m = 0;
          end
        end else if (lb) idle_m = 0;
        else begin
          locked_m = 0; ptr_m = (owner_m + 1) % N;
        end
      end else if (locked_m) begin
        idle_m++;
        if (idle_m == TMO) begin
          locked_m = 0; ptr_m = (owner_m + 1) % N;
        end
      end
    end
    @(negedge clk);
    check({tag, "/osel"}, 32'(osel), 32'(osel_m));
    check({tag, "/osel_wr"}, 32'(osel_wr), 32'(wr_m));
    check({tag, "/grant_id"}, 32'(grant_id), 32'(gid_m));
    check({tag, "/locked"}, 32'(locked), 32'(locked_m));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    valid = '1; idx = '0; val = '0; lock = '0;
    osel_m = '0; wr_m = 0; gid_m = 0; locked_m = 0; ptr_m = 0; idle_m = 0; owner_m = 0;
    step("rst");
    step("rst");
    check("rst_osel", 32'(osel), 0);
    check("rst_locked", 32'(locked), 0);
    rst = 1'b0;
    valid = '0;
    drive(1, 1, 3, 1, 0);
    #1 check("single_ready", 32'(ready), 32'h2);
    step("single");
    check("single_osel", 32'(osel), 32'h08);
    check("single_wr", 32'(osel_wr), 1);
    rst = 1'b1; valid = '0;
    step("rst2");
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1, i, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step("fair");
      check("fair_gid", 32'(grant_id), 32'(k % 4));
      if (k == 3) check("fair_osel", 32'(osel), 32'h0F);
    end
    valid = '0; clr = 1'b1;
    step("lk_clr");
    clr = 1'b0;
    drive(2, 1, 3, 1, 1);
    step("lock1");
    drive(0, 1, 0, 1, 0); drive(1, 1, 1, 1, 0); drive(2, 1, 4, 1, 1);
    step("lock2");
    check("lock2_gid", 32'(grant_id), 2);
    drive(2, 1, 5, 1, 0);
    step("lock3");
    check("lock_osel", 32'(osel), 32'h38);
    drive(2, 0, 0, 0, 0); drive(3, 1, 2, 0, 0);
    step("after_lock");
    check("after_lock_gid", 32'(grant_id), 3);
    valid = '0;
    drive(2, 1, 0, 0, 1);
    step("relock");
    drive(0, 1, 1, 0, 0); drive(1, 1, 1, 0, 0); drive(2, 1, 0, 0, 0);
    step("relock_end");
    drive(2, 0, 0, 0, 0);
    step("wrap");
    check("wrap_gid", 32'(grant_id), 0);
    rst = 1'b1; valid = '0;
    step("rst3");
    rst = 1'b0;
    drive(0, 1, 2, 1, 1);
    step("tmo_lock");
    drive(0, 0, 0, 0, 0); drive(1, 1, 1, 1, 0);
    for (int j = 1; j <= TMO; j++) begin
      step("tmo_wait");
      check("tmo_locked", 32'(locked), 32'(j < TMO));
    end
    #1 check("tmo_ready", 32'(ready), 32'h2);
    step("tmo_grant");
    rst = 1'b1; valid = '0;
    step("rst4");
    rst = 1'b0;
    for (int b = 0; b < W; b++) begin
      valid = '0;
      drive(b % N, 1, b, 1, 0);
      step("fill");
    end
    check("fill_osel", 32'(osel), 32'h3F);
    valid = '0; clr = 1'b1;
    drive(0, 1, 0, 1, 0);
    #1 check("clr_ready", 32'(ready), 0);
    step("clr");
    check("clr_osel", 32'(osel), 0);
    clr = 1'b0; valid = '0;
    drive(1, 1, 7, 1, 0);
    step("oor7");
    check("oor7_wr", 32'(osel_wr), 0);
    check("oor7_gid", 32'(grant_id), 1);
    drive(1, 0, 0, 0, 0); drive(2, 1, 6, 1, 0);
    step("oor6");
    check("oor6_osel", 32'(osel), 0);
    for (int c = 0; c < 2000; c++) begin
      rst = $urandom_range(199) == 0;
      clr = $urandom_range(19) == 0;
      valid = ($urandom_range(3) == 0) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      idx = (N*IW)'($urandom);
      val = N'($urandom);
      lock = N'($urandom & $urandom);
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
